prog_sequencer: RTL and testbench

- Controller for the instruction-fetch program counter: launches each of NPROG stored programs in turn, runs it, and reports completion.
- On a Start pulse it forces the PC to the program's base address, enables fetch until the decoder reports a halt instruction, drains the pipeline, then raises Done.
- Sits between the top-level testbench/host handshake (Start/Done) and the PC / decoder.

---
 rtl/prog_pkg.sv | 21 ++
 rtl/prog_sequencer_if.sv | 32 +++
 rtl/prog_sequencer_run_cycle_counter.sv | 32 +++
 rtl/prog_sequencer.sv | 105 ++++++++++
 tb/tb_prog_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/prog_pkg.sv
// Shared types and program-image constants for the program sequencer.
package prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int NPROG = 3;

  // Base address of each resident program, indexed by program number.
  localparam logic [31:0] BASE_ADDR [NPROG] = '{32'h000, 32'h100, 32'h200};

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Host/PC/decoder handshake bundle for prog_sequencer.
// Carries Timeout only when PROG_WATCHDOG_EN is defined.
interface prog_sequencer_if #(
  parameter int L     = 10,
  parameter int NPROG = 3,
  parameter int CNT_W = 16
);
  localparam int IDX_W = prog_pkg::idx_w(NPROG);

  logic             Start;
  logic             Halt;
  logic             PcLoad;
  logic [L-1:0]     PcLoadAddr;
  logic             Run;
  logic             Done;
  logic [IDX_W-1:0] ProgIdx;
  logic [CNT_W-1:0] CycCnt;
`ifdef PROG_WATCHDOG_EN
  logic             Timeout;

  modport master (input Start, Halt,
                  output PcLoad, PcLoadAddr, Run, Done, ProgIdx, CycCnt, Timeout);
  modport slave  (output Start, Halt,
                  input PcLoad, PcLoadAddr, Run, Done, ProgIdx, CycCnt, Timeout);
`else
  modport master (input Start, Halt,
                  output PcLoad, PcLoadAddr, Run, Done, ProgIdx, CycCnt);
  modport slave  (output Start, Halt,
                  input PcLoad, PcLoadAddr, Run, Done, ProgIdx, CycCnt);
`endif

endinterface

// File: rtl/prog_sequencer_run_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear.
// With PROG_WATCHDOG_EN it also flags the cycle that brings the count to WD_LIMIT.
module run_cycle_counter #(
  parameter int CNT_W = 16
`ifdef PROG_WATCHDOG_EN
  , parameter int WD_LIMIT = 4095
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
`ifdef PROG_WATCHDOG_EN
  , output logic           limit
`endif
);

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef PROG_WATCHDOG_EN
  // Raised one cycle early so the final count lands exactly on WD_LIMIT.
  assign limit = en && (cnt >= CNT_W'(WD_LIMIT - 1));
`endif

endmodule

// File: rtl/prog_sequencer.sv
// Program-launch sequencer: LOAD -> RUN until halt -> DRAIN -> DONE, cycling through NPROG programs.
// Optional run watchdog and Timeout output enabled by PROG_WATCHDOG_EN.
module prog_sequencer #(
  parameter int L         = 10,
  parameter int NPROG     = prog_pkg::NPROG,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 16
`ifdef PROG_WATCHDOG_EN
  , parameter int WD_LIMIT = 4095
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  prog_sequencer_if.master bus
);
  import prog_pkg::*;

  localparam int IDX_W = idx_w(NPROG);
  localparam int DW    = idx_w(DRAIN_CYC);

  seq_state_t       state, state_nx;
  logic [DW-1:0]    dcnt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cyc_cnt;
  logic             cnt_clr, cnt_en, wd_hit;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      dcnt  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      dcnt  <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      if ((state != DONE) && (state_nx == DONE)) begin
        idx <= (idx == IDX_W'(NPROG - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      IDLE:  if (bus.Start) begin
               state_nx = LOAD;
               cnt_clr  = 1'b1;
             end
      LOAD:  state_nx = RUN;
      RUN:   begin
               cnt_en = 1'b1;
               if (bus.Halt || wd_hit) state_nx = DRAIN;
             end
      DRAIN: if (dcnt == DW'(DRAIN_CYC - 1)) state_nx = DONE;
      DONE:  if (bus.Start) begin
               state_nx = LOAD;
               cnt_clr  = 1'b1;
             end
      default: state_nx = IDLE;
    endcase
  end

`ifdef PROG_WATCHDOG_EN
  logic timeout;

  run_cycle_counter #(.CNT_W(CNT_W), .WD_LIMIT(WD_LIMIT)) u_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cyc_cnt),
    .limit (wd_hit)
  );

  // Sticky through DRAIN/DONE; only a fresh launch or reset clears it.
  always_ff @(posedge Clk) begin
    if (Reset || (state_nx == LOAD)) begin
      timeout <= 1'b0;
    end else if ((state == RUN) && wd_hit) begin
      timeout <= 1'b1;
    end
  end

  assign bus.Timeout = timeout;
`else
  run_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cyc_cnt)
  );

  assign wd_hit = 1'b0;
`endif

  assign bus.PcLoad     = (state == LOAD);
  assign bus.Run        = (state == RUN);
  assign bus.Done       = (state == DONE);
  assign bus.ProgIdx    = idx;
  assign bus.CycCnt     = cyc_cnt;
  assign bus.PcLoadAddr = L'(BASE_ADDR[idx]);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: vector table plus multi-cycle corner sequences.
module tb_prog_sequencer;

  localparam int L         = 10;
  localparam int NPROG     = 3;
  localparam int DRAIN_CYC = 2;
  localparam int CNT_W     = 5;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  prog_sequencer_if #(.L(L), .NPROG(NPROG), .CNT_W(CNT_W)) bus ();

  prog_sequencer #(
    .L(L), .NPROG(NPROG), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)
`ifdef PROG_WATCHDOG_EN
    , .WD_LIMIT(20)
`endif
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic start;
    logic halt;
    logic pcload;
    int   addr;
    logic run;
    logic done;
    int   idx;
    int   cyc;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   pl_cnt = 0;
  int   run_n  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic h, input logic pl, input int a,
                     input logic r, input logic d, input int i, input int c);
    vec_t v;
    v.start = s; v.halt = h; v.pcload = pl; v.addr = a;
    v.run = r; v.done = d; v.idx = i; v.cyc = c;
    tbl.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic pl, input int a, input logic r,
                            input logic d, input int i, input int c);
    chk({tag, ".PcLoad"},     32'(bus.PcLoad),     32'(pl));
    chk({tag, ".PcLoadAddr"}, 32'(bus.PcLoadAddr), 32'(a));
    chk({tag, ".Run"},        32'(bus.Run),        32'(r));
    chk({tag, ".Done"},       32'(bus.Done),       32'(d));
    chk({tag, ".ProgIdx"},    32'(bus.ProgIdx),    32'(i));
    chk({tag, ".CycCnt"},     32'(bus.CycCnt),     32'(c));
  endtask

  task automatic step();
    @(negedge Clk);
    if (bus.PcLoad === 1'b1) pl_cnt++;
  endtask

  task automatic wait_pcload(input string tag);
    for (int i = 0; i < 10 && bus.PcLoad !== 1'b1; i++) step();
    chk({tag, ".pcload_seen"}, 32'(bus.PcLoad), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 10 && bus.Done !== 1'b1; i++) step();
    chk({tag, ".done_seen"}, 32'(bus.Done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // First program: launch, 10 RUN cycles with Halt on the 10th, drain, done.
    add(1, 0, 1'b0, 'h000, 0, 0, 0, 0);
    add(0, 0, 1'b1, 'h000, 0, 0, 0, 0);
    for (int k = 2; k <= 10; k++) add(0, 0, 1'b0, 'h000, 1, 0, 0, k - 2);
    add(0, 1, 1'b0, 'h000, 1, 0, 0, 9);
    add(0, 0, 1'b0, 'h000, 0, 0, 0, 10);
    add(1, 0, 1'b0, 'h000, 0, 0, 0, 10);
    add(0, 0, 1'b0, 'h100, 0, 1, 1, 10);
    add(0, 0, 1'b0, 'h100, 0, 1, 1, 10);
    add(1, 0, 1'b0, 'h100, 0, 1, 1, 10);
    // Second program: Start+Halt together in the only RUN cycle.
    add(0, 0, 1'b1, 'h100, 0, 0, 1, 0);
    add(1, 1, 1'b0, 'h100, 1, 0, 1, 0);
    add(0, 0, 1'b0, 'h100, 0, 0, 1, 1);
    add(0, 0, 1'b0, 'h100, 0, 0, 1, 1);
    add(0, 0, 1'b0, 'h200, 0, 1, 2, 1);

    bus.Start = 1'b0;
    bus.Halt  = 1'b0;
    Reset     = 1'b1;
    repeat (2) @(negedge Clk);
    check_outs("reset", 1'b0, 'h000, 0, 0, 0, 0);
`ifdef PROG_WATCHDOG_EN
    chk("reset.Timeout", 32'(bus.Timeout), 32'd0);
`endif
    Reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      check_outs($sformatf("vec%0d", i), tbl[i].pcload, tbl[i].addr, tbl[i].run,
                 tbl[i].done, tbl[i].idx, tbl[i].cyc);
      bus.Start = tbl[i].start;
      bus.Halt  = tbl[i].halt;
      @(negedge Clk);
    end

    // Start held high: one PcLoad per pass through DONE, ProgIdx wraps 2 -> 0.
    pl_cnt    = 0;
    bus.Start = 1'b1;
    wait_pcload("held0");
    chk("held0.addr", 32'(bus.PcLoadAddr), 32'h200);
    chk("held0.done_dropped", 32'(bus.Done), 32'd0);
    step();
    chk("held0.run", 32'(bus.Run), 32'd1);
    bus.Halt = 1'b1;
    step();
    bus.Halt = 1'b0;
    chk("held0.run_low", 32'(bus.Run), 32'd0);
    wait_done("held0");
    chk("held0.wrap_idx", 32'(bus.ProgIdx), 32'd0);
    wait_pcload("held1");
    chk("held1.addr", 32'(bus.PcLoadAddr), 32'h000);
    step();
    bus.Halt = 1'b1;
    step();
    bus.Halt = 1'b0;
    wait_done("held1");
    chk("held1.idx", 32'(bus.ProgIdx), 32'd1);
    wait_pcload("held2");
    chk("held2.addr", 32'(bus.PcLoadAddr), 32'h100);
    chk("held.pcload_count", 32'(pl_cnt), 32'd3);

    // Reset in the middle of program 1's RUN.
    bus.Start = 1'b0;
    repeat (3) step();
    chk("midrun.run", 32'(bus.Run), 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_outs("midrun_reset", 1'b0, 'h000, 0, 0, 0, 0);
    step();
    check_outs("midrun_idle", 1'b0, 'h000, 0, 0, 0, 0);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    check_outs("relaunch", 1'b1, 'h000, 0, 0, 0, 0);
    step();

`ifdef PROG_WATCHDOG_EN
    // No Halt: watchdog ends RUN after exactly 20 cycles.
    run_n = 0;
    while (bus.Run === 1'b1 && run_n < 60) begin
      run_n++;
      step();
    end
    chk("wd.run_cycles", 32'(run_n), 32'd20);
    chk("wd.cyc", 32'(bus.CycCnt), 32'd20);
    chk("wd.timeout_early", 32'(bus.Done), 32'd0);
    wait_done("wd");
    chk("wd.timeout", 32'(bus.Timeout), 32'd1);
    chk("wd.idx", 32'(bus.ProgIdx), 32'd1);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("wd.load", 32'(bus.PcLoad), 32'd1);
    chk("wd.timeout_clr", 32'(bus.Timeout), 32'd0);
`else
    // Counter saturates at all-ones during a long run.
    repeat (40) step();
    chk("sat.run", 32'(bus.Run), 32'd1);
    chk("sat.cyc", 32'(bus.CycCnt), 32'd31);
    bus.Halt = 1'b1;
    step();
    bus.Halt = 1'b0;
    wait_done("sat");
    chk("sat.cyc_hold", 32'(bus.CycCnt), 32'd31);
    chk("sat.idx", 32'(bus.ProgIdx), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
